// File: rtl/missile_hit_detect_if.sv
// Missile/enemy position inputs and hit-detector status outputs.
// master drives positions and reads status; slave is the detector.
interface missile_hit_detect_if;
    logic        pause;
    logic [9:0]  m_x;
    logic [9:0]  m_y;
    logic        show_valid;
    logic [9:0]  e_x;
    logic [9:0]  e_y;
    logic        hit_pulse;
    logic        kill_pulse;
    logic [3:0]  enemy_hp;
    logic [1:0]  enemy_state;
    logic        enemy_visible;
    logic [15:0] score;

    modport master (
        output pause, m_x, m_y, show_valid, e_x, e_y,
        input  hit_pulse, kill_pulse, enemy_hp, enemy_state, enemy_visible, score
    );

    modport slave (
        input  pause, m_x, m_y, show_valid, e_x, e_y,
        output hit_pulse, kill_pulse, enemy_hp, enemy_state, enemy_visible, score
    );
endinterface

// File: rtl/missile_hit_detect.sv
// Swept missile/enemy overlap detection with enemy hp, flash, death/respawn and score.
// One hit is counted per shot; pause freezes all state.
module missile_hit_detect #(
    parameter int unsigned M_W           = 20,
    parameter int unsigned M_H           = 10,
    parameter int unsigned E_W           = 40,
    parameter int unsigned E_H           = 40,
    parameter int unsigned MAX_HP        = 3,
    parameter int unsigned FLASH_TICKS   = 8,
    parameter int unsigned RESPAWN_TICKS = 32,
    parameter int unsigned KILL_BONUS    = 5
) (
    input  logic                  clk_22,
    input  logic                  rst,
    missile_hit_detect_if.slave   bus_io
);

    localparam int unsigned TMax = (FLASH_TICKS > RESPAWN_TICKS) ? FLASH_TICKS : RESPAWN_TICKS;
    localparam int unsigned TW   = ($clog2(TMax) < 2) ? 2 : $clog2(TMax);

    typedef enum logic [1:0] {
        StAlive = 2'b00,
        StFlash = 2'b01,
        StDead  = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    hp_q, hp_d;
    logic [15:0]   score_q, score_d;
    logic          sv_q, sv_d;
    logic          armed_q, armed_d;
    logic [9:0]    prev_x_q, prev_x_d;
    logic          hit_q, hit_d;
    logic          kill_q, kill_d;

    logic          rise;
    logic [10:0]   lo, hi, e_right, e_bottom, m_bottom;
    logic          x_ov, y_ov, hit;
    logic          is_kill;
    logic [16:0]   score_sum;

    // Swept x span covers everything the missile passed since the last tick.
    always_comb begin
        rise     = bus_io.show_valid & ~sv_q;
        lo       = sv_q ? {1'b0, prev_x_q} : {1'b0, bus_io.m_x};
        hi       = {1'b0, bus_io.m_x} + 11'(M_W);
        e_right  = {1'b0, bus_io.e_x} + 11'(E_W);
        e_bottom = {1'b0, bus_io.e_y} + 11'(E_H);
        m_bottom = {1'b0, bus_io.m_y} + 11'(M_H);
        x_ov     = (lo < e_right) && (hi > {1'b0, bus_io.e_x});
        y_ov     = ({1'b0, bus_io.m_y} < e_bottom) && (m_bottom > {1'b0, bus_io.e_y});
        hit      = (armed_q | rise) & bus_io.show_valid & x_ov & y_ov &
                   (state_q == StAlive) & ~bus_io.pause;
        is_kill  = (hp_q <= 4'd1);
        score_sum = {1'b0, score_q} + (is_kill ? 17'(KILL_BONUS + 1) : 17'd1);
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        hp_d     = hp_q;
        score_d  = score_q;
        sv_d     = sv_q;
        armed_d  = armed_q;
        prev_x_d = prev_x_q;
        hit_d    = 1'b0;
        kill_d   = 1'b0;

        if (!bus_io.pause) begin
            sv_d     = bus_io.show_valid;
            prev_x_d = bus_io.m_x;

            // Non-ALIVE overlaps leave armed untouched so the shot survives the flash.
            if (!bus_io.show_valid || hit) begin
                armed_d = 1'b0;
            end else if (rise) begin
                armed_d = 1'b1;
            end

            unique case (state_q)
                StAlive: begin
                    if (hit) begin
                        hit_d   = 1'b1;
                        timer_d = '0;
                        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                        if (is_kill) begin
                            kill_d  = 1'b1;
                            hp_d    = 4'd0;
                            state_d = StDead;
                        end else begin
                            hp_d    = hp_q - 4'd1;
                            state_d = StFlash;
                        end
                    end
                end
                StFlash: begin
                    if (timer_q == TW'(FLASH_TICKS - 1)) begin
                        state_d = StAlive;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StDead: begin
                    if (timer_q == TW'(RESPAWN_TICKS - 1)) begin
                        state_d = StAlive;
                        timer_d = '0;
                        hp_d    = 4'(MAX_HP);
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StAlive;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            state_q  <= StAlive;
            timer_q  <= '0;
            hp_q     <= 4'(MAX_HP);
            score_q  <= '0;
            sv_q     <= 1'b0;
            armed_q  <= 1'b0;
            prev_x_q <= '0;
            hit_q    <= 1'b0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            hp_q     <= hp_d;
            score_q  <= score_d;
            sv_q     <= sv_d;
            armed_q  <= armed_d;
            prev_x_q <= prev_x_d;
            hit_q    <= hit_d;
            kill_q   <= kill_d;
        end
    end

    always_comb begin
        bus_io.hit_pulse   = hit_q;
        bus_io.kill_pulse  = kill_q;
        bus_io.enemy_hp    = hp_q;
        bus_io.enemy_state = state_q;
        bus_io.score       = score_q;
        unique case (state_q)
            StAlive: bus_io.enemy_visible = 1'b1;
            StFlash: bus_io.enemy_visible = ~timer_q[1];
            default: bus_io.enemy_visible = 1'b0;
        endcase
    end

endmodule
